// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: fetch state encoding, decoder class codes, PC offsets.
// The HALT state is only present when FETCH_TIMEOUT_EN is defined.
`timescale 1ns/1ps
package core_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01
`ifdef FETCH_TIMEOUT_EN
    ,
    ST_HALT  = 2'b10
`endif
  } fetch_state_e;

  localparam logic [2:0] INSTR_ADD = 3'b000;
  localparam logic [2:0] INSTR_SUB = 3'b001;
  localparam logic [2:0] INSTR_MOV = 3'b010;
  localparam logic [2:0] INSTR_CMP = 3'b011;
  localparam logic [2:0] INSTR_STR = 3'b100;
  localparam logic [2:0] INSTR_LDR = 3'b101;
  localparam logic [2:0] INSTR_B   = 3'b110;
  localparam logic [2:0] INSTR_BL  = 3'b111;

  localparam int unsigned PC_STEP     = 32'd4;
  localparam int unsigned PC_PIPE_OFS = 32'd8;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic [31:0]       IMemRdata;
  logic              IMemValid;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdata,
    input  IMemValid
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdata,
    output IMemValid
  );

endinterface

// File: rtl/branch_target_gen.sv
// Branch target: PC+8 plus the sign-extended 24-bit word offset, word aligned.
`timescale 1ns/1ps
module branch_target_gen #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [23:0]       imm24,
  input  logic [ADDR_W-1:0] pc_plus8,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'd3);

  logic [ADDR_W-1:0] offset_s;

  assign offset_s = {{(ADDR_W-26){imm24[23]}}, imm24, 2'b00};
  assign target   = (pc_plus8 + offset_s) & ALIGN_MASK;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and Z flag, fetches one word, holds it for decode, then steps or branches.
// Optional build macro FETCH_TIMEOUT_EN adds a fetch watchdog, a HALT state and the FetchErr output.
`timescale 1ns/1ps
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                Stall,
  input  logic                PCSrc,
  input  logic [2:0]          InstrCode,
  input  logic                ALUZero,
  output logic [31:0]         Instr,
  output logic                InstrValid,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PCPlus8,
  output logic                Flags,
  output logic                LinkWrite,
  output logic [ADDR_W-1:0]   LinkData
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                FetchErr
`endif
);

  if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("instr_fetch_unit: RESET_PC must be word aligned and TIMEOUT_CYC nonzero");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              flags_q, flags_d;
  logic              imem_req_s, instr_valid_s, link_write_s;
  logic [ADDR_W-1:0] pc_plus4_s, pc_plus8_s, target_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign FetchErr = err_q;
`endif

  assign pc_plus4_s = pc_q + ADDR_W'(PC_STEP);
  assign pc_plus8_s = pc_q + ADDR_W'(PC_PIPE_OFS);

  branch_target_gen #(.ADDR_W(ADDR_W)) u_branch_target_gen (
    .imm24    (instr_q[23:0]),
    .pc_plus8 (pc_plus8_s),
    .target   (target_s)
  );

  // Next-state, next-PC/flag/instruction and per-cycle control outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    flags_d       = flags_q;
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    link_write_s  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem.IMemValid) begin
          instr_d = imem.IMemRdata;
          state_d = ST_EXEC;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        instr_valid_s = 1'b1;
        if (!Stall) begin
          pc_d         = PCSrc ? target_s : pc_plus4_s;
          link_write_s = PCSrc && (InstrCode == INSTR_BL);
          state_d      = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d        = {CNT_W{1'b0}};
`endif
          if (InstrCode == INSTR_CMP) begin
            flags_d = ALUZero;
          end else begin
            flags_d = flags_q;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, PC, held instruction and Z flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      flags_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Control strobes are suppressed while reset is being applied.
  assign imem.IMemReq  = imem_req_s & rst_n;
  assign imem.IMemAddr = pc_q;
  assign InstrValid    = instr_valid_s & rst_n;
  assign LinkWrite     = link_write_s & rst_n;
  assign Instr         = instr_q;
  assign PC            = pc_q;
  assign PCPlus8       = pc_plus8_s;
  assign Flags         = flags_q;
  assign LinkData      = pc_plus4_s;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/exec vectors, monitor checks on fetch accept and EXEC.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import core_pkg::*;

  typedef struct {
    logic [31:0] word;
    int          wait_n;
    logic [31:0] addr;
    int          stall_n;
    logic        pcsrc;
    logic [2:0]  code;
    logic        az;
    logic [31:0] pc;
    logic [31:0] p8;
    logic        flags;
    logic        lw;
    logic [31:0] ld;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, PCSrc, ALUZero;
  logic [2:0]  InstrCode;
  logic [31:0] Instr, PC, PCPlus8, LinkData;
  logic        InstrValid, Flags, LinkWrite;
`ifdef FETCH_TIMEOUT_EN
  logic        FetchErr;
`endif

  int n_vec = 0;
  int n_err = 0;
  vec_t        exec_q[$];
  logic [31:0] addr_q[$];
  vec_t        vecs[10];
  vec_t        mon_e;
  logic [31:0] mon_a;

  instr_fetch_unit_if #(.ADDR_W(32)) imem_if ();

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem_if),
    .Stall(Stall), .PCSrc(PCSrc), .InstrCode(InstrCode), .ALUZero(ALUZero),
    .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus8(PCPlus8),
    .Flags(Flags), .LinkWrite(LinkWrite), .LinkData(LinkData)
`ifdef FETCH_TIMEOUT_EN
    , .FetchErr(FetchErr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected $finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] word, input int wait_n, input logic [31:0] addr,
                              input int stall_n, input logic pcsrc, input logic [2:0] code,
                              input logic az, input logic [31:0] pc, input logic [31:0] p8,
                              input logic flags, input logic lw, input logic [31:0] ld);
    vec_t v;
    v.word = word; v.wait_n = wait_n; v.addr = addr; v.stall_n = stall_n;
    v.pcsrc = pcsrc; v.code = code; v.az = az; v.pc = pc; v.p8 = p8;
    v.flags = flags; v.lw = lw; v.ld = ld;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.wait_n; i++) begin
      imem_if.IMemValid = 1'b0;
      imem_if.IMemRdata = 32'h0BAD_F00D;
      step();
    end
    imem_if.IMemValid = 1'b1;
    imem_if.IMemRdata = v.word;
    addr_q.push_back(v.addr);
    step();
    exec_q.push_back(v);
    PCSrc     = v.pcsrc;
    InstrCode = v.code;
    ALUZero   = v.az;
    for (int i = 0; i < v.stall_n; i++) begin
      Stall             = 1'b1;
      imem_if.IMemValid = 1'b1;
      imem_if.IMemRdata = 32'hDEAD_BEEF;
      step();
    end
    Stall             = 1'b0;
    imem_if.IMemValid = 1'b0;
    step();
    PCSrc     = 1'b0;
    InstrCode = INSTR_ADD;
    ALUZero   = 1'b0;
  endtask

  // Monitor: check address on every accepted fetch and the held instruction on every EXEC cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_if.IMemReq && imem_if.IMemValid) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fetch_unexpected: got request at %h, expected none", imem_if.IMemAddr);
        end else begin
          mon_a = addr_q.pop_front();
          chk("fetch_addr", imem_if.IMemAddr, mon_a);
          chk("fetch_ivalid", {31'd0, InstrValid}, 32'd0);
        end
      end
      if (InstrValid) begin
        if (exec_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL exec_unexpected: got InstrValid=1 with Instr %h, expected none", Instr);
        end else begin
          mon_e = exec_q[0];
          chk("exec_instr", Instr, mon_e.word);
          chk("exec_pc", PC, mon_e.pc);
          chk("exec_flags", {31'd0, Flags}, {31'd0, mon_e.flags});
          chk("exec_imemreq", {31'd0, imem_if.IMemReq}, 32'd0);
          if (Stall) begin
            chk("stall_linkwrite", {31'd0, LinkWrite}, 32'd0);
          end else begin
            chk("exec_pcplus8", PCPlus8, mon_e.p8);
            chk("exec_linkwrite", {31'd0, LinkWrite}, {31'd0, mon_e.lw});
            chk("exec_linkdata", LinkData, mon_e.ld);
            void'(exec_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    //            word          wt addr          st pcs code       az pc            p8            f  lw ld
    vecs[0] = mk(32'hE081_1002, 0, 32'h0000_0000, 0, 0, INSTR_ADD, 0, 32'h0000_0000, 32'h0000_0008, 0, 0, 32'h0000_0004);
    vecs[1] = mk(32'hE242_2001, 0, 32'h0000_0004, 0, 0, INSTR_ADD, 0, 32'h0000_0004, 32'h0000_000C, 0, 0, 32'h0000_0008);
    vecs[2] = mk(32'hE351_0000, 2, 32'h0000_0008, 2, 0, INSTR_CMP, 1, 32'h0000_0008, 32'h0000_0010, 0, 0, 32'h0000_000C);
    vecs[3] = mk(32'hE080_0001, 1, 32'h0000_000C, 0, 0, INSTR_ADD, 0, 32'h0000_000C, 32'h0000_0014, 1, 0, 32'h0000_0010);
    vecs[4] = mk(32'hEA00_0002, 0, 32'h0000_0010, 0, 1, INSTR_B,   0, 32'h0000_0010, 32'h0000_0018, 1, 0, 32'h0000_0014);
    vecs[5] = mk(32'hEA00_0006, 0, 32'h0000_0020, 3, 1, INSTR_B,   0, 32'h0000_0020, 32'h0000_0028, 1, 0, 32'h0000_0024);
    vecs[6] = mk(32'hEBFF_FFFE, 0, 32'h0000_0040, 1, 1, INSTR_BL,  0, 32'h0000_0040, 32'h0000_0048, 1, 1, 32'h0000_0044);
    vecs[7] = mk(32'hEAFF_FFED, 0, 32'h0000_0040, 0, 1, INSTR_B,   0, 32'h0000_0040, 32'h0000_0048, 1, 0, 32'h0000_0044);
    vecs[8] = mk(32'hE081_1002, 0, 32'hFFFF_FFFC, 0, 0, INSTR_ADD, 0, 32'hFFFF_FFFC, 32'h0000_0004, 1, 0, 32'h0000_0000);
    vecs[9] = mk(32'hE351_0000, 0, 32'h0000_0000, 0, 0, INSTR_CMP, 0, 32'h0000_0000, 32'h0000_0008, 0, 0, 32'h0000_0004);

    rst_n = 1'b0; Stall = 1'b0; PCSrc = 1'b1; InstrCode = INSTR_BL; ALUZero = 1'b1;
    imem_if.IMemValid = 1'b1; imem_if.IMemRdata = 32'h1234_5678;
    step(); step();
    #4;
    chk("rst_imemreq", {31'd0, imem_if.IMemReq}, 32'd0);
    chk("rst_ivalid", {31'd0, InstrValid}, 32'd0);
    chk("rst_linkwrite", {31'd0, LinkWrite}, 32'd0);
    step();
    rst_n = 1'b1; imem_if.IMemValid = 1'b0; PCSrc = 1'b0; InstrCode = INSTR_ADD; ALUZero = 1'b0;
    #4;
    chk("post_rst_addr", imem_if.IMemAddr, 32'h0000_0000);
    chk("post_rst_instr", Instr, 32'h0000_0000);
    chk("post_rst_flags", {31'd0, Flags}, 32'd0);
    chk("post_rst_imemreq", {31'd0, imem_if.IMemReq}, 32'd1);
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while waiting in FETCH, with a response arriving during the reset cycle.
    imem_if.IMemValid = 1'b0;
    step(); step();
    rst_n = 1'b0; imem_if.IMemValid = 1'b1; imem_if.IMemRdata = 32'hDEAD_BEEF;
    #4;
    chk("midrst_imemreq", {31'd0, imem_if.IMemReq}, 32'd0);
    step();
    rst_n = 1'b1; imem_if.IMemValid = 1'b0;
    #4;
    chk("midrst_addr", imem_if.IMemAddr, 32'h0000_0000);
    chk("midrst_instr", Instr, 32'h0000_0000);
    chk("midrst_flags", {31'd0, Flags}, 32'd0);
    step();
    run_vec(vecs[9]);

`ifdef FETCH_TIMEOUT_EN
    rst_n = 1'b0; step();
    rst_n = 1'b1; imem_if.IMemValid = 1'b0;
    step(); step(); step();
    #4;
    chk("to_err_before", {31'd0, FetchErr}, 32'd0);
    chk("to_req_before", {31'd0, imem_if.IMemReq}, 32'd1);
    step();
    #4;
    chk("to_err_after", {31'd0, FetchErr}, 32'd1);
    chk("to_req_after", {31'd0, imem_if.IMemReq}, 32'd0);
    step();
    imem_if.IMemValid = 1'b1;
    step(); step();
    #4;
    chk("halt_req", {31'd0, imem_if.IMemReq}, 32'd0);
    chk("halt_ivalid", {31'd0, InstrValid}, 32'd0);
    chk("halt_err", {31'd0, FetchErr}, 32'd1);
    step();
    rst_n = 1'b0; imem_if.IMemValid = 1'b0; step();
    rst_n = 1'b1;
    #4;
    chk("halt_rst_err", {31'd0, FetchErr}, 32'd0);
    step();
`endif

    step(); step();
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("exec_q_drained", exec_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that feeds the single-cycle ARM-subset control unit.
- Owns the PC register and the Z flag register, issues requests to instruction memory, and holds each fetched word for decode.
- Consumes the decoder's PCSrc and InstrCode to compute the next PC (sequential or branch), update Z on CMP, and produce the BL link write.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- ADDR_W, 32, PC/address width.
- TIMEOUT_CYC, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- IMemReq  out  1  instruction-memory read request.
- IMemAddr  out  ADDR_W  read address, always equal to PC.
- IMemRdata  in  32  returned instruction word.
- IMemValid  in  1  IMemRdata valid this cycle.
- Stall  in  1  hold the current instruction in EXEC.
- PCSrc  in  1  decoder branch-taken select.
- InstrCode  in  3  decoder class: ADD 000, SUB 001, MOV 010, CMP 011, STR 100, LDR 101, B 110, BL 111.
- ALUZero  in  1  ALU zero result of the current instruction.
- Instr  out  32  held instruction to the decoder.
- InstrValid  out  1  Instr is being executed this cycle.
- PC  out  ADDR_W  address of Instr.
- PCPlus8  out  ADDR_W  PC+8, the architectural R15 read value.
- Flags  out  1  registered Z bit to the decoder.
- LinkWrite  out  1  write LinkData to R14 this cycle.
- LinkData  out  ADDR_W  PC+4.

Behaviour:
- States: FETCH, EXEC; HALT exists only with FETCH_TIMEOUT_EN.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state=FETCH, PC=RESET_PC, Instr=0, Flags=0.
  - IMemReq, InstrValid and LinkWrite are 0 during the reset cycle.
  - Any in-flight memory response is discarded.
- FETCH:
  - IMemReq=1, IMemAddr=PC, InstrValid=0, LinkWrite=0.
  - When IMemValid=1: Instr<=IMemRdata, go to EXEC.
  - Minimum latency: request to EXEC is 1 cycle when IMemValid arrives in the same cycle as the request.
- EXEC:
  - IMemReq=0, InstrValid=1.
  - If Stall=1: remain in EXEC; PC, Flags and Instr are held; LinkWrite=0.
  - If Stall=0, at the edge:
    - PC <= PCSrc ? branch target : PC+4.
    - If InstrCode==011, Flags <= ALUZero.
    - Go to FETCH.
  - LinkWrite=1 combinationally in the single non-stalled EXEC cycle when InstrCode==111 and PCSrc=1.
- IMemValid outside FETCH is ignored.
- Branch target:
  - PCPlus8 + ({{6{Instr[23]}},Instr[23:0]} << 2), modulo 2^ADDR_W.
  - Result bits [1:0] are forced to 00.
- PC+4 and PC+8 wrap modulo 2^ADDR_W; 32'hFFFF_FFFC+4 gives 0.
- Flags only changes in a non-stalled EXEC cycle; a conditional instruction sees the Z of the last completed CMP.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Adds output FetchErr (1 bit, reset 0) and a cycle counter that clears on entry to FETCH and counts each FETCH cycle without IMemValid.
  - When the count reaches TIMEOUT_CYC: FetchErr<=1 (sticky), state<=HALT.
  - HALT: IMemReq=0, InstrValid=0; left only by reset.
- Undefined: FETCH waits indefinitely; no counter, no FetchErr port, no HALT state.

Decomposition:
- Shared package (core_pkg):
  - fetch state encoding.
  - InstrCode constants INSTR_ADD..INSTR_BL.
  - PC_STEP=4, PC_PIPE_OFS=8.
- One sub-module: branch_target_gen. Combinational; imm24 and PCPlus8 in, aligned target out.

Test Plan:
- Reset then IMemValid=1 every cycle with words W0,W1 → IMemAddr 0x0 then 0x4; InstrValid pulses every second cycle; Instr=W0 then W1.
- Instr=0xEA000002, PC=0x10, PCSrc=1, InstrCode=110 → next IMemAddr=0x20.
- Instr=0xEBFFFFFE (BL −2), PC=0x40, PCSrc=1, InstrCode=111 → LinkWrite=1 with LinkData=0x44 for one cycle; next IMemAddr=0x40.
- CMP (InstrCode=011) with ALUZero=1 → Flags=1 from the next cycle. Then ADD with ALUZero=0 → Flags stays 1.
- Stall=1 for 3 EXEC cycles → PC, Instr and Flags held, LinkWrite=0, no IMemReq; advance on the 4th cycle.
- rst_n=0 while in FETCH with IMemValid=0 → after release, IMemAddr=RESET_PC.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, and IMemValid never asserted → FetchErr=1 after 4 FETCH cycles, then IMemReq=0 until reset.
